dram_refresh_arb: RTL

DRAM_REFRESH_ARB -- requirements
Module: dram_refresh_arb

---
 rtl/sun2_mem_pkg.sv | 19 +
 rtl/sync2.sv | 27 ++
 rtl/dram_refresh_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/sun2_mem_pkg.sv
// Shared memory-controller definitions: arbiter state encoding
// and default refresh timing constants.
package sun2_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU,
        ST_ACK,
        ST_CSR,
        ST_RAS,
        ST_PRE
    } arb_state_t;

    localparam int T_CSR_DEF = 1;
    localparam int T_RAS_DEF = 4;
    localparam int T_RP_DEF  = 3;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Flops reset to RST_VAL so an inactive level is seen after reset.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/dram_refresh_arb.sv
// DRAM refresh/CPU arbiter issuing CAS-before-RAS refresh cycles.
// Strobes decode straight from the state register so reset frees them at once.
module dram_refresh_arb
    import sun2_mem_pkg::*;
#(
    parameter int T_CSR = T_CSR_DEF,
    parameter int T_RAS = T_RAS_DEF,
    parameter int T_RP  = T_RP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rreq_n,
    input  logic        cpu_req,
    input  logic        cpu_done,
    output logic        ren_n,
    output logic        cpu_gnt,
    output logic        ras_n,
    output logic        cas_n,
    output logic        refresh_busy,
    output logic [15:0] refresh_count
);

    localparam logic [CNT_W-1:0] CSR_LD = CNT_W'(T_CSR - 1);
    localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [15:0]      ref_cnt_q;
    logic             ref_inc;
    logic             rreq_sync_n;
    logic             pending;

    sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rreq_n),
        .q    (rreq_sync_n)
    );

    assign pending = ~rreq_sync_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ref_inc) begin
                ref_cnt_q <= ref_cnt_q + 16'd1;
            end
        end
    end

    // Shared phase counter: reloaded when entering CSR, RAS or PRE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = ST_ACK;
                end else if (cpu_req) begin
                    state_d = ST_CPU;
                end
            end
            ST_CPU: begin
                if (cpu_done) begin
                    state_d = pending ? ST_ACK : ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_CSR;
                cnt_d   = CSR_LD;
            end
            ST_CSR: begin
                if (cnt_q == '0) begin
                    state_d = ST_RAS;
                    cnt_d   = RAS_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RAS: begin
                if (cnt_q == '0) begin
                    state_d = ST_PRE;
                    cnt_d   = RP_LD;
                    ref_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ren_n         = (state_q != ST_ACK);
    assign cpu_gnt       = (state_q == ST_CPU);
    assign ras_n         = (state_q != ST_RAS);
    assign cas_n         = ~((state_q == ST_CSR) || (state_q == ST_RAS));
    assign refresh_busy  = ~((state_q == ST_IDLE) || (state_q == ST_CPU));
    assign refresh_count = ref_cnt_q;

endmodule
